field_reducer: RTL and testbench

//  Line-clear engine that sits directly downstream of control_fsm. It is started when

---
 rtl/field_reducer.sv | 141 ++++++++++++++
 tb/tb_field_reducer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_reducer.sv
// Line-clear engine: drops full rows bottom-up, compacts the rest downward,
// zero-fills the top and publishes a per-column top-occupied-row vector.
module field_reducer #(
   parameter int WIDTH      = 8,
   parameter int MEM_WIDTH  = 10,
   parameter int MEM_HEIGHT = 20
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic [WIDTH-1:0]           rd_addr,
   input  logic [MEM_WIDTH-1:0]       rd_data,
   output logic                       wr_en,
   output logic [WIDTH-1:0]           wr_addr,
   output logic [MEM_WIDTH-1:0]       wr_data,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           lines_cleared,
   output logic [MEM_WIDTH*WIDTH-1:0] border
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_EV,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0] LAST   = WIDTH'(MEM_HEIGHT - 1);
   localparam logic [WIDTH-1:0] HEIGHT = WIDTH'(MEM_HEIGHT);

   // Element 0 sits at the MSBs so the array flattens straight onto border.
   typedef logic [0:MEM_WIDTH-1][WIDTH-1:0] colvec_t;

   localparam colvec_t EMPTY = {MEM_WIDTH{HEIGHT}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH:0]   w_q, w_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lc_q, lc_d;
   colvec_t          shadow_q, shadow_d;
   colvec_t          border_q, border_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         w_q      <= '0;
         cnt_q    <= '0;
         lc_q     <= '0;
         shadow_q <= EMPTY;
         border_q <= EMPTY;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         w_q      <= w_d;
         cnt_q    <= cnt_d;
         lc_q     <= lc_d;
         shadow_q <= shadow_d;
         border_q <= border_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      w_d      = w_q;
      cnt_d    = cnt_q;
      lc_d     = lc_q;
      shadow_d = shadow_q;
      border_d = border_q;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d      = LAST;
               w_d      = {1'b0, LAST};
               cnt_d    = '0;
               lc_d     = '0;
               shadow_d = EMPTY;
               state_d  = S_RD;
            end
         end
         S_RD: begin
            state_d = S_EV;
         end
         S_EV: begin
            if (&rd_data) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               wr_en   = 1'b1;
               wr_addr = w_q[WIDTH-1:0];
               wr_data = rd_data;
               for (int c = 0; c < MEM_WIDTH; c++) begin
                  if (rd_data[MEM_WIDTH-1-c]) begin
                     shadow_d[c] = w_q[WIDTH-1:0];
                  end
               end
               w_d = w_q - 1'b1;
            end
            if (r_q == '0) begin
               state_d = (cnt_d == '0) ? S_DONE : S_FILL;
            end else begin
               r_d     = r_q - 1'b1;
               state_d = S_RD;
            end
         end
         S_FILL: begin
            wr_en   = 1'b1;
            wr_addr = w_q[WIDTH-1:0];
            if (w_q == '0) begin
               state_d = S_DONE;
            end else begin
               w_d = w_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Publish only on entry to DONE so the vector is stable all run.
      if (state_d == S_DONE && state_q != S_DONE) begin
         border_d = shadow_d;
         lc_d     = cnt_d;
      end
   end

   assign rd_addr       = r_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign lines_cleared = lc_q;
   assign border        = border_q;

endmodule

// File: tb/tb_field_reducer.sv
// Bench for field_reducer: playfield memory model plus a row-compaction
// reference computed directly from the initial field contents.
module tb_field_reducer;

   localparam int W  = 8;
   localparam int MW = 10;
   localparam int MH = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  rd_addr, wr_addr, lines_cleared;
   logic [MW-1:0] rd_data, wr_data;
   logic          wr_en, busy, done;
   logic [MW*W-1:0] border;

   logic [MW-1:0] mem    [0:31];
   logic [MW-1:0] init_f [0:MH-1];
   logic [MW-1:0] exp_f  [0:MH-1];
   int            exp_cnt;
   int            exp_bd [0:MW-1];

   int checks = 0;
   int errors = 0;

   int r_done, r_writes, r_dones, r_first_wr, r_lc1;
   bit r_busy_after, r_wr_bad;

   field_reducer #(.WIDTH(W), .MEM_WIDTH(MW), .MEM_HEIGHT(MH)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done),
      .lines_cleared(lines_cleared), .border(border)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_data <= mem[rd_addr[4:0]];
      if (wr_en) mem[wr_addr[4:0]] <= wr_data;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int bfield(input int c);
      return int'(border[(MW-c)*W-1 -: W]);
   endfunction

   task automatic load_field();
      for (int r = 0; r < MH; r++) mem[r] = init_f[r];
   endtask

   // Surviving rows keep their order and settle at the bottom.
   task automatic compute_model();
      int k;
      k = MH - 1;
      for (int r = 0; r < MH; r++) exp_f[r] = '0;
      for (int r = MH - 1; r >= 0; r--) begin
         if (init_f[r] != '1) begin
            exp_f[k] = init_f[r];
            k--;
         end
      end
      exp_cnt = k + 1;
      for (int c = 0; c < MW; c++) begin
         exp_bd[c] = MH;
         for (int r = MH - 1; r >= 0; r--)
            if (exp_f[r][MW-1-c]) exp_bd[c] = r;
      end
   endtask

   task automatic random_field();
      for (int r = 0; r < MH; r++) begin
         case ($urandom_range(0, 3))
            0:       init_f[r] = '1;
            1:       init_f[r] = '0;
            default: init_f[r] = MW'($urandom);
         endcase
      end
   endtask

   // Runs one reduction; cycle c is the c-th cycle after the accepting edge.
   task automatic do_run(input bit pulse);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      r_done = -1;
      r_writes = 0;
      r_dones = 0;
      r_first_wr = -1;
      r_lc1 = -1;
      r_busy_after = 1'b1;
      r_wr_bad = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         start = pulse && (c == 5 || c == 30);
         if (c == 1) r_lc1 = int'(lines_cleared);
         if (wr_en) begin
            r_writes++;
            if (r_first_wr < 0) r_first_wr = c;
         end
         if (wr_en && (done || !busy)) r_wr_bad = 1'b1;
         if (done) begin
            r_dones++;
            if (r_done < 0) r_done = c;
         end
         if (r_done > 0 && c == r_done + 1) r_busy_after = busy;
         if (r_done > 0 && c >= r_done + 6) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b wr_en=%b want 0 0 0",
                  busy, done, wr_en);
      end
      checks++;
      if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
         errors++;
         $display("FAIL reset_addr: rd=%0d wa=%0d wd=%h want 0 0 0",
                  rd_addr, wr_addr, wr_data);
      end
      checks++;
      if (lines_cleared !== '0) begin
         errors++;
         $display("FAIL reset_lc: got %0d want 0", lines_cleared);
      end
      bad = 0;
      for (int c = 0; c < MW; c++) if (bfield(c) != MH) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_border: got %h want all %0d", border, MH);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      int dc [0:3];
      int lc [0:3];
      int bad, fr;
      dc = '{41, 42, 43, 61};
      lc = '{0, 1, 2, 20};
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < MH; r++) init_f[r] = '0;
         case (t)
            1: begin
               init_f[19] = '1;
               init_f[18] = 10'b1000000000;
            end
            2: begin
               init_f[17] = '1;
               init_f[19] = '1;
               init_f[18] = 10'b0000000001;
            end
            3: for (int r = 0; r < MH; r++) init_f[r] = '1;
            default: ;
         endcase
         compute_model();
         load_field();
         do_run(1'b0);
         checks++;
         if (r_done != dc[t]) begin
            errors++;
            $display("FAIL dir%0d_latency: done cycle %0d want %0d",
                     t, r_done, dc[t]);
         end
         checks++;
         if (int'(lines_cleared) != lc[t]) begin
            errors++;
            $display("FAIL dir%0d_lines: got %0d want %0d",
                     t, lines_cleared, lc[t]);
         end
         checks++;
         if (r_writes != MH || r_dones != 1 || r_wr_bad) begin
            errors++;
            $display("FAIL dir%0d_writes: writes=%0d dones=%0d bad=%b want %0d 1 0",
                     t, r_writes, r_dones, r_wr_bad, MH);
         end
         checks++;
         if (r_busy_after !== 1'b0 || r_lc1 != 0) begin
            errors++;
            $display("FAIL dir%0d_busy_lc: busy_after=%b lc@1=%0d want 0 0",
                     t, r_busy_after, r_lc1);
         end
         bad = 0;
         fr = 0;
         for (int r = MH - 1; r >= 0; r--)
            if (mem[r] !== exp_f[r]) begin bad++; fr = r; end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL dir%0d_field: row %0d got %b want %b",
                     t, fr, mem[fr], exp_f[fr]);
         end
         bad = 0;
         for (int c = 0; c < MW; c++) if (bfield(c) != exp_bd[c]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL dir%0d_border: got %h", t, border);
         end
         case (t)
            1: begin
               checks++;
               if (bfield(0) != 19 || bfield(1) != 20) begin
                  errors++;
                  $display("FAIL dir1_col0: col0=%0d col1=%0d want 19 20",
                           bfield(0), bfield(1));
               end
            end
            2: begin
               checks++;
               if (bfield(9) != 19 || mem[19] !== 10'b0000000001) begin
                  errors++;
                  $display("FAIL dir2_col9: col9=%0d row19=%b want 19 0000000001",
                           bfield(9), mem[19]);
               end
            end
            3: begin
               checks++;
               if (r_first_wr != 41) begin
                  errors++;
                  $display("FAIL dir3_first_write: cycle %0d want 41",
                           r_first_wr);
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_random();
      int bad, fr;
      for (int it = 0; it < 8; it++) begin
         random_field();
         compute_model();
         load_field();
         do_run(1'b0);
         checks++;
         if (r_done != 2 * MH + exp_cnt + 1) begin
            errors++;
            $display("FAIL rnd%0d_latency: done cycle %0d want %0d",
                     it, r_done, 2 * MH + exp_cnt + 1);
         end
         checks++;
         if (int'(lines_cleared) != exp_cnt || r_writes != MH) begin
            errors++;
            $display("FAIL rnd%0d_lines: lc=%0d writes=%0d want %0d %0d",
                     it, lines_cleared, r_writes, exp_cnt, MH);
         end
         bad = 0;
         fr = 0;
         for (int r = MH - 1; r >= 0; r--)
            if (mem[r] !== exp_f[r]) begin bad++; fr = r; end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rnd%0d_field: row %0d got %b want %b",
                     it, fr, mem[fr], exp_f[fr]);
         end
         bad = 0;
         fr = 0;
         for (int c = 0; c < MW; c++)
            if (bfield(c) != exp_bd[c]) begin bad++; fr = c; end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rnd%0d_border: col %0d got %0d want %0d",
                     it, fr, bfield(fr), exp_bd[fr]);
         end
      end
   endtask

   task automatic test_restart_ignored();
      int bad;
      for (int r = 0; r < MH; r++) init_f[r] = '0;
      init_f[19] = '1;
      init_f[18] = 10'b0101010101;
      init_f[12] = 10'b1010101010;
      init_f[11] = '1;
      init_f[5]  = 10'b0011000000;
      compute_model();
      load_field();
      do_run(1'b1);
      checks++;
      if (r_dones != 1 || r_done != 2 * MH + exp_cnt + 1) begin
         errors++;
         $display("FAIL restart: dones=%0d cycle=%0d want 1 %0d",
                  r_dones, r_done, 2 * MH + exp_cnt + 1);
      end
      bad = 0;
      for (int r = 0; r < MH; r++) if (mem[r] !== exp_f[r]) bad++;
      for (int c = 0; c < MW; c++) if (bfield(c) != exp_bd[c]) bad++;
      checks++;
      if (bad != 0 || int'(lines_cleared) != exp_cnt) begin
         errors++;
         $display("FAIL restart_result: %0d diffs lc=%0d want 0 %0d",
                  bad, lines_cleared, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      int bad, fr;
      for (int r = 0; r < MH; r++) init_f[r] = 10'b1100000011;
      load_field();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (wr_en !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: wr_en=%b busy=%b want 1 1", wr_en, busy);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_abort: busy=%b wr_en=%b done=%b want 0 0 0",
                  busy, wr_en, done);
      end
      bad = 0;
      for (int c = 0; c < MW; c++) if (bfield(c) != MH) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_border: got %h want all %0d", border, MH);
      end
      @(negedge clk);
      reset = 1'b0;
      random_field();
      init_f[19] = '1;
      init_f[0]  = 10'b0000100000;
      compute_model();
      load_field();
      do_run(1'b0);
      checks++;
      if (r_done != 2 * MH + exp_cnt + 1 || int'(lines_cleared) != exp_cnt) begin
         errors++;
         $display("FAIL mid_rerun: cycle=%0d lc=%0d want %0d %0d",
                  r_done, lines_cleared, 2 * MH + exp_cnt + 1, exp_cnt);
      end
      bad = 0;
      fr = 0;
      for (int r = 0; r < MH; r++)
         if (mem[r] !== exp_f[r]) begin bad++; fr = r; end
      for (int c = 0; c < MW; c++) if (bfield(c) != exp_bd[c]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_rerun_result: %0d diffs, row %0d got %b want %b",
                  bad, fr, mem[fr], exp_f[fr]);
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) mem[r] = '0;
      test_reset();
      test_directed();
      test_random();
      test_restart_ignored();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
